mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STREAK, default 4, is the maximum number of consecutive data grants issued while a fetch is waiting; legal range 1-15.
REQ-002 i_clk  input  1  is the single clock; all state updates on its rising edge.
REQ-003 i_rst_n  input  1  is the reset: asynchronous, active-low.
REQ-004 i_imem_req  input  1  requests an instruction fetch.
REQ-005 i_imem_addr  input  32  is the fetch byte address.
REQ-006 o_imem_gnt  output  1  signals that the fetch is accepted this cycle.
REQ-007 o_imem_rvalid  output  1  signals that o_imem_rdata is valid.
REQ-008 o_imem_rdata  output  32  is the fetch read data.
REQ-009 i_dmem_req  input  1  requests a data access.
REQ-010 i_dmem_wen  input  1  selects the access type: 1 = write, 0 = read.
REQ-011 i_dmem_addr  input  32  is the data byte address.
REQ-012 i_dmem_wdata  input  32  is the data write data.
REQ-013 i_dmem_mask  input  4  is the byte-enable mask.
REQ-014 o_dmem_gnt  output  1  signals that the data access is accepted this cycle.
REQ-015 o_dmem_rvalid  output  1  signals that o_dmem_rdata is valid; it is never asserted for writes.
REQ-016 o_dmem_rdata  output  32  is the data read data.
REQ-017 o_mem_addr  output  32  is the shared single-port memory address.
REQ-018 o_mem_ren  output  1  is the shared memory read enable.
REQ-019 o_mem_wen  output  1  is the shared memory write enable.
REQ-020 o_mem_wdata  output  32  is the shared memory write data.
REQ-021 o_mem_mask  output  4  is the shared memory byte mask.
REQ-022 i_mem_rdata  input  32  is the shared memory read data, valid one cycle after the o_mem_ren cycle.
REQ-023 o_conflict_cnt  output  16  counts cycles in which both requests were high.

Function
REQ-024 Grants SHALL be combinational from the requests and the current state; at most one grant per cycle; a grant is never issued without its request.
REQ-025 Only the data request high -> data grant; only the fetch request high -> fetch grant; neither high -> no grant and o_mem_ren = o_mem_wen = 0.
REQ-026 Both requests high:
- data wins while streak < STREAK;
- fetch wins when streak == STREAK.
REQ-027 Streak counter (4 bits):
- +1 on each data grant issued while i_imem_req is high;
- cleared on any fetch grant;
- unchanged otherwise.
REQ-028 Granted port drives o_mem_addr the same cycle.
- Fetch grant: o_mem_ren = 1, o_mem_mask = 4'hF.
- Data grant: o_mem_ren = ~i_dmem_wen, o_mem_wen = i_dmem_wen, o_mem_mask = i_dmem_mask, o_mem_wdata = i_dmem_wdata.
REQ-029 Ungranted cycle: o_mem_addr, o_mem_wdata, o_mem_mask = 0.
REQ-030 Each read grant SHALL record a one-entry tag (none, fetch, data); next cycle the tagged port's rvalid = 1 and its rdata = i_mem_rdata. Latency = exactly 1 cycle.
REQ-031 Untagged port: rdata = 0 and rvalid = 0.
REQ-032 Back-to-back read grants SHALL be supported every cycle with no bubble; the tag is overwritten each cycle.
REQ-033 A write grant SHALL set the tag to none; write completion is signalled by o_dmem_gnt alone.
REQ-034 A requester holds its request, address and data stable until granted; the arbiter does not check this.
REQ-035 o_conflict_cnt SHALL increment on every cycle with both requests high, saturate at 16'hFFFF, and never wrap.

Reset
REQ-036 i_rst_n low SHALL immediately clear the streak counter to 0, the tag to none, and o_conflict_cnt to 0.
REQ-037 While i_rst_n is low, all grants, rvalids and memory enables SHALL be forced to 0 regardless of the requests.
REQ-038 A read granted in the cycle before reset asserts SHALL produce no rvalid.
REQ-039 The first edge after release SHALL behave as though the block came from idle.

Verification
REQ-040 Fetch only, addr 0x10, mem returns 0xDEADBEEF -> gnt at cycle t; o_imem_rvalid = 1 with 0xDEADBEEF at t+1; o_dmem_rvalid stays 0.
REQ-041 Both ports held high continuously, STREAK = 4, data reads -> grant pattern D,D,D,D,I repeated; o_conflict_cnt = 5 after the first 5 cycles.
REQ-042 Data write, addr 0x20, mask 0011, wdata 0x0000ABCD -> o_mem_wen = 1 and o_mem_mask = 0011 in the gnt cycle; no rvalid follows.
REQ-043 Alternating fetch and data reads on consecutive cycles -> rvalids alternate one cycle delayed, each rdata matched to its own address.
REQ-044 Fetch read granted, then i_rst_n pulsed low mid-cycle before the next edge -> no o_imem_rvalid; streak and counter read 0 after release.
REQ-045 Both requests forced high for 70000 cycles -> o_conflict_cnt holds 16'hFFFF.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the arbiter and the shared memory.
// The slave modport is the arbiter side; the master modport is the requester/memory side.
interface mem_arbiter_if;
  logic        i_imem_req;
  logic [31:0] i_imem_addr;
  logic        o_imem_gnt;
  logic        o_imem_rvalid;
  logic [31:0] o_imem_rdata;

  logic        i_dmem_req;
  logic        i_dmem_wen;
  logic [31:0] i_dmem_addr;
  logic [31:0] i_dmem_wdata;
  logic [3:0]  i_dmem_mask;
  logic        o_dmem_gnt;
  logic        o_dmem_rvalid;
  logic [31:0] o_dmem_rdata;

  logic [31:0] o_mem_addr;
  logic        o_mem_ren;
  logic        o_mem_wen;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_mask;
  logic [31:0] i_mem_rdata;

  modport slave (
    input  i_imem_req, i_imem_addr,
    output o_imem_gnt, o_imem_rvalid, o_imem_rdata,
    input  i_dmem_req, i_dmem_wen, i_dmem_addr, i_dmem_wdata, i_dmem_mask,
    output o_dmem_gnt, o_dmem_rvalid, o_dmem_rdata,
    output o_mem_addr, o_mem_ren, o_mem_wen, o_mem_wdata, o_mem_mask,
    input  i_mem_rdata
  );

  modport master (
    output i_imem_req, i_imem_addr,
    input  o_imem_gnt, o_imem_rvalid, o_imem_rdata,
    output i_dmem_req, i_dmem_wen, i_dmem_addr, i_dmem_wdata, i_dmem_mask,
    input  o_dmem_gnt, o_dmem_rvalid, o_dmem_rdata,
    input  o_mem_addr, o_mem_ren, o_mem_wen, o_mem_wdata, o_mem_mask,
    output i_mem_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetches and data accesses onto one single-port memory.
// Data has priority, but a waiting fetch is forced through after STREAK data grants.
module mem_arbiter #(
  parameter int unsigned STREAK = 4
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  mem_arbiter_if.slave  bus,
  output logic [15:0]   o_conflict_cnt
);

  typedef enum logic [1:0] {TAG_NONE, TAG_IMEM, TAG_DMEM} tag_e;

  localparam logic [3:0] STREAK_LIM = 4'(STREAK);

  logic [3:0]  r_streak;
  tag_e        r_tag;
  logic [15:0] r_conflict_cnt;

  logic w_both;
  logic w_imem_gnt;
  logic w_dmem_gnt;
  tag_e w_tag_nxt;

  assign w_both = bus.i_imem_req & bus.i_dmem_req;

  // Grants are forced low while reset is held, independent of the requests.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    w_imem_gnt = 1'b0;
    w_dmem_gnt = 1'b0;
    if (i_rst_n) begin
      if (bus.i_imem_req && (!bus.i_dmem_req || r_streak >= STREAK_LIM)) w_imem_gnt = 1'b1;
      else if (bus.i_dmem_req)                                           w_dmem_gnt = 1'b1;
    end
  end

  always_comb begin
    bus.o_mem_addr  = '0;
    bus.o_mem_ren   = 1'b0;
    bus.o_mem_wen   = 1'b0;
    bus.o_mem_wdata = '0;
    bus.o_mem_mask  = '0;
    w_tag_nxt       = TAG_NONE;
    if (w_imem_gnt) begin
      bus.o_mem_addr = bus.i_imem_addr;
      bus.o_mem_ren  = 1'b1;
      bus.o_mem_mask = 4'hF;
      w_tag_nxt      = TAG_IMEM;
    end else if (w_dmem_gnt) begin
      bus.o_mem_addr  = bus.i_dmem_addr;
      bus.o_mem_ren   = ~bus.i_dmem_wen;
      bus.o_mem_wen   = bus.i_dmem_wen;
      bus.o_mem_wdata = bus.i_dmem_wdata;
      bus.o_mem_mask  = bus.i_dmem_mask;
      w_tag_nxt       = bus.i_dmem_wen ? TAG_NONE : TAG_DMEM;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_streak       <= '0;
      r_tag          <= TAG_NONE;
      r_conflict_cnt <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      r_tag <= w_tag_nxt;
      if (w_imem_gnt)                       r_streak <= '0;
      else if (w_dmem_gnt && bus.i_imem_req) r_streak <= r_streak + 4'd1;
      if (w_both && r_conflict_cnt != 16'hFFFF) r_conflict_cnt <= r_conflict_cnt + 16'd1;
    end
  end

  // Read data is steered only to the port whose read was granted last cycle.
  assign bus.o_imem_gnt    = w_imem_gnt;
  assign bus.o_dmem_gnt    = w_dmem_gnt;
  assign bus.o_imem_rvalid = (r_tag == TAG_IMEM);
  assign bus.o_dmem_rvalid = (r_tag == TAG_DMEM);
  assign bus.o_imem_rdata  = (r_tag == TAG_IMEM) ? bus.i_mem_rdata : '0;
  assign bus.o_dmem_rdata  = (r_tag == TAG_DMEM) ? bus.i_mem_rdata : '0;
  assign o_conflict_cnt    = r_conflict_cnt;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus constrained-random traffic
// compared against a behavioural model of the arbitration and read-return rules.
module tb_mem_arbiter;
  localparam int STREAK = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] conflict_cnt;

  always #5 clk = ~clk;

  mem_arbiter_if bus ();

  mem_arbiter #(.STREAK(STREAK)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .bus            (bus),
    .o_conflict_cnt (conflict_cnt)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: fetch waits at most STREAK data grants; reads return next cycle.
  int          m_streak = 0;
  int          m_tag = 0;       // 0 none, 1 fetch, 2 data
  int          m_cnt = 0;
  logic [31:0] m_rd_addr = '0;

  // Memory contents seen by the bench acting as the shared memory.
  logic        mem_pend = 1'b0;
  logic [31:0] mem_addr = '0;

  // Samples from the most recent checked cycle, used by directed checks.
  bit          s_gi, s_gd;
  logic        s_igt, s_dgt, s_irv, s_drv, s_wen;
  logic [31:0] s_irdata;
  logic [3:0]  s_mask;
  logic [15:0] s_cnt;

  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a == 32'h10) return 32'hDEADBEEF;
    return {a[15:0] ^ 16'h5A3C, ~a[31:16]};
  endfunction

  task automatic model_reset();
    m_streak = 0;
    m_tag    = 0;
    m_cnt    = 0;
  endtask

  task automatic cycle(input bit do_chk = 1'b1);
    bit          gi, gd, both;
    logic [31:0] e_addr, e_wdata;
    logic        e_ren, e_wen;
    logic [3:0]  e_mask;
    @(negedge clk);
    both = bus.i_imem_req && bus.i_dmem_req;
    gi   = bus.i_imem_req && (!bus.i_dmem_req || m_streak >= STREAK);
    gd   = bus.i_dmem_req && !gi;
    e_addr = '0; e_wdata = '0; e_ren = 1'b0; e_wen = 1'b0; e_mask = '0;
    if (gi) begin
      e_addr = bus.i_imem_addr; e_ren = 1'b1; e_mask = 4'hF;
    end else if (gd) begin
      e_addr = bus.i_dmem_addr; e_ren = !bus.i_dmem_wen; e_wen = bus.i_dmem_wen;
      e_mask = bus.i_dmem_mask; e_wdata = bus.i_dmem_wdata;
    end
    s_gi = gi; s_gd = gd;
    s_igt = bus.o_imem_gnt; s_dgt = bus.o_dmem_gnt;
    s_irv = bus.o_imem_rvalid; s_drv = bus.o_dmem_rvalid; s_irdata = bus.o_imem_rdata;
    s_wen = bus.o_mem_wen; s_mask = bus.o_mem_mask; s_cnt = conflict_cnt;
    if (do_chk) begin
      check("imem_gnt",   32'(bus.o_imem_gnt),    32'(gi));
      check("dmem_gnt",   32'(bus.o_dmem_gnt),    32'(gd));
      check("mem_addr",   bus.o_mem_addr,         e_addr);
      check("mem_ren",    32'(bus.o_mem_ren),     32'(e_ren));
      check("mem_wen",    32'(bus.o_mem_wen),     32'(e_wen));
      check("mem_mask",   32'(bus.o_mem_mask),    32'(e_mask));
      check("mem_wdata",  bus.o_mem_wdata,        e_wdata);
      check("imem_rvld",  32'(bus.o_imem_rvalid), 32'(m_tag == 1));
      check("dmem_rvld",  32'(bus.o_dmem_rvalid), 32'(m_tag == 2));
      check("imem_rdata", bus.o_imem_rdata,       (m_tag == 1) ? memf(m_rd_addr) : 32'h0);
      check("dmem_rdata", bus.o_dmem_rdata,       (m_tag == 2) ? memf(m_rd_addr) : 32'h0);
      check("conf_cnt",   32'(conflict_cnt),      32'(m_cnt));
    end
    mem_pend = bus.o_mem_ren;
    mem_addr = bus.o_mem_addr;
    @(posedge clk);
    m_tag = 0;
    if (gi) begin
      m_tag = 1; m_rd_addr = bus.i_imem_addr; m_streak = 0;
    end else if (gd) begin
      if (!bus.i_dmem_wen) begin
        m_tag = 2; m_rd_addr = bus.i_dmem_addr;
      end
      if (bus.i_imem_req) m_streak++;
    end
    if (both && m_cnt < 65535) m_cnt++;
    #1 bus.i_mem_rdata = mem_pend ? memf(mem_addr) : $urandom;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_igt"},  32'(bus.o_imem_gnt),    32'h0);
    check({tag, "_dgt"},  32'(bus.o_dmem_gnt),    32'h0);
    check({tag, "_irv"},  32'(bus.o_imem_rvalid), 32'h0);
    check({tag, "_drv"},  32'(bus.o_dmem_rvalid), 32'h0);
    check({tag, "_ren"},  32'(bus.o_mem_ren),     32'h0);
    check({tag, "_wen"},  32'(bus.o_mem_wen),     32'h0);
    check({tag, "_cnt"},  32'(conflict_cnt),      32'h0);
  endtask

  task automatic set_dmem(input logic req, input logic wen, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] mask);
    bus.i_dmem_req = req; bus.i_dmem_wen = wen; bus.i_dmem_addr = addr;
    bus.i_dmem_wdata = wdata; bus.i_dmem_mask = mask;
  endtask

  initial begin
    bus.i_imem_req = 1'b1; bus.i_imem_addr = 32'h100;
    set_dmem(1'b1, 1'b0, 32'h200, 32'h0, 4'hF);
    bus.i_mem_rdata = '0;

    // Reset held with both requests high: everything forced off.
    #2 check_reset_outputs("rst_hold");
    bus.i_imem_req = 1'b0; bus.i_dmem_req = 1'b0;
    #4 rst_n = 1'b1;
    model_reset();

    // Single fetch to 0x10 returns DEADBEEF one cycle later.
    bus.i_imem_req = 1'b1; bus.i_imem_addr = 32'h10;
    cycle();
    check("fetch_gnt", 32'(s_igt), 32'h1);
    bus.i_imem_req = 1'b0;
    cycle();
    check("fetch_rvld", 32'(s_irv), 32'h1);
    check("fetch_rdata", s_irdata, 32'hDEADBEEF);
    check("fetch_no_drv", 32'(s_drv), 32'h0);

    // Data write: mask 0011, no read return afterwards.
    set_dmem(1'b1, 1'b1, 32'h20, 32'h0000ABCD, 4'b0011);
    cycle();
    check("wr_wen", 32'(s_wen), 32'h1);
    check("wr_mask", 32'(s_mask), 32'h3);
    bus.i_dmem_req = 1'b0;
    cycle();
    check("wr_no_drv", 32'(s_drv), 32'h0);

    // Alternating single-port reads on consecutive cycles.
    for (int k = 0; k < 6; k++) begin
      bus.i_imem_req = (k % 2 == 0); bus.i_imem_addr = 32'h1000 + 32'(k * 4);
      set_dmem(k % 2 == 1, 1'b0, 32'h2000 + 32'(k * 8), 32'h0, 4'hF);
      cycle();
    end
    bus.i_imem_req = 1'b0; bus.i_dmem_req = 1'b0;
    cycle();

    // Build a streak, grant a fetch, then pulse reset before the return edge.
    bus.i_imem_req = 1'b1; bus.i_imem_addr = 32'h44;
    set_dmem(1'b1, 1'b0, 32'h88, 32'h0, 4'hF);
    cycle(); cycle();
    bus.i_dmem_req = 1'b0;
    cycle();
    check("pre_rst_fetch", 32'(s_igt), 32'h1);
    bus.i_dmem_req = 1'b1;
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("rst_pulse");
    model_reset();
    bus.i_imem_req = 1'b0; bus.i_dmem_req = 1'b0;
    #1 rst_n = 1'b1;
    cycle();
    check("rst_no_irv", 32'(s_irv), 32'h0);

    // Both ports held: D,D,D,D,I repeating from a cleared streak.
    bus.i_imem_req = 1'b1; bus.i_imem_addr = 32'h300;
    set_dmem(1'b1, 1'b0, 32'h400, 32'h0, 4'hF);
    for (int k = 0; k < 10; k++) begin
      cycle();
      check("pattern_dgnt", 32'(s_dgt), 32'(k % 5 != 4));
      if (k == 5) check("pattern_cnt5", 32'(s_cnt), 32'd5);
    end

    // Random traffic; a requester changes only after being granted.
    for (int k = 0; k < 3000; k++) begin
      if (!bus.i_imem_req || s_gi) begin
        bus.i_imem_req  = ($urandom_range(0, 9) < 6);
        bus.i_imem_addr = $urandom;
      end
      if (!bus.i_dmem_req || s_gd) begin
        set_dmem($urandom_range(0, 9) < 6, 1'($urandom_range(0, 1)),
                 $urandom, $urandom, 4'($urandom_range(0, 15)));
      end
      cycle();
    end

    // Long conflict run to saturate the counter.
    bus.i_imem_req = 1'b1;
    set_dmem(1'b1, 1'b0, 32'h500, 32'h0, 4'hF);
    for (int k = 0; k < 70000; k++) cycle(1'b0);
    cycle();
    check("cnt_saturate", 32'(s_cnt), 32'h0000FFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
